axis_frame_gen: RTL and testbench

AXI-stream frame source that drives the slave side of axis_fifo (frame-FIFO mode, DROP_BAD_FRAME) in test and loopback builds. It accepts one command per frame (length, seed, ID, dest, bad flag) and emits a frame of that length with tkeep, tlast, tid, tdest and tuser. tuser on the last beat marks the frame bad, so downstream frame FIFOs can be exercised for drop behaviour.

---
 rtl/axis_frame_gen.sv | 143 ++++++++++++++
 tb/tb_axis_frame_gen.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/axis_frame_gen.sv
// rtl/axis_frame_gen.sv - AXI-stream test frame source driven by per-frame commands
// Optional AXIS_FRAME_GEN_SEQ_HDR_EN: bytes 0..3 of each frame carry the frame count at accept.
module axis_frame_gen #(
  parameter int   DATA_WIDTH           = 64,
  parameter int   KEEP_WIDTH           = DATA_WIDTH / 8,
  parameter int   ID_WIDTH             = 8,
  parameter int   DEST_WIDTH           = 8,
  parameter int   LEN_WIDTH            = 16,
  parameter logic USER_BAD_FRAME_VALUE = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic [7:0]            cmd_seed,
  input  logic [ID_WIDTH-1:0]   cmd_id,
  input  logic [DEST_WIDTH-1:0] cmd_dest,
  input  logic                  cmd_bad,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [ID_WIDTH-1:0]   m_axis_tid,
  output logic [DEST_WIDTH-1:0] m_axis_tdest,
  output logic                  m_axis_tuser,
  output logic                  status_busy,
  output logic                  status_len_err,
  output logic [31:0]           status_frame_count
);

  typedef enum logic {IDLE, SEND} state_t;

  localparam logic [LEN_WIDTH-1:0] KW_LEN = LEN_WIDTH'(KEEP_WIDTH);

  state_t               state;
  logic [LEN_WIDTH-1:0] rem;     // bytes left, counting the beat currently on the bus
  logic [7:0]           base;    // pattern value of byte 0 of the beat on the bus
  logic                 bad_q;

  logic [LEN_WIDTH-1:0]  rem_nxt;
  logic [7:0]            base_nxt;
  logic [KEEP_WIDTH-1:0] first_keep, next_keep;
  logic [DATA_WIDTH-1:0] first_data, next_data;

  function automatic logic [KEEP_WIDTH-1:0] beat_keep(input logic [LEN_WIDTH-1:0] left);
    beat_keep = '0;
    for (int j = 0; j < KEEP_WIDTH; j++) beat_keep[j] = (left > LEN_WIDTH'(j));
  endfunction

  function automatic logic [DATA_WIDTH-1:0] beat_data(input logic [7:0] b0,
                                                      input logic [KEEP_WIDTH-1:0] keep);
    beat_data = '0;
    for (int j = 0; j < KEEP_WIDTH; j++)
      if (keep[j]) beat_data[8*j +: 8] = b0 + 8'(j);
  endfunction

  assign rem_nxt  = rem - KW_LEN;
  assign base_nxt = base + 8'(KEEP_WIDTH);

  always_comb begin
    first_keep = beat_keep(cmd_len);
    first_data = beat_data(cmd_seed, first_keep);
`ifdef AXIS_FRAME_GEN_SEQ_HDR_EN
    // Header bytes never extend past the frame length, so short frames get a truncated count.
    for (int j = 0; j < 4; j++)
      if (first_keep[j]) first_data[8*j +: 8] = status_frame_count[8*j +: 8];
`endif
    next_keep = beat_keep(rem_nxt);
    next_data = beat_data(base_nxt, next_keep);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= IDLE;
      rem                <= '0;
      base               <= '0;
      bad_q              <= 1'b0;
      cmd_ready          <= 1'b0;
      m_axis_tdata       <= '0;
      m_axis_tkeep       <= '0;
      m_axis_tvalid      <= 1'b0;
      m_axis_tlast       <= 1'b0;
      m_axis_tid         <= '0;
      m_axis_tdest       <= '0;
      m_axis_tuser       <= 1'b0;
      status_busy        <= 1'b0;
      status_len_err     <= 1'b0;
      status_frame_count <= '0;
    end else begin
      status_len_err <= 1'b0;
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            if (cmd_len == '0) begin
              status_len_err <= 1'b1;
            end else begin
              state         <= SEND;
              cmd_ready     <= 1'b0;
              status_busy   <= 1'b1;
              rem           <= cmd_len;
              base          <= cmd_seed;
              bad_q         <= cmd_bad;
              m_axis_tvalid <= 1'b1;
              m_axis_tdata  <= first_data;
              m_axis_tkeep  <= first_keep;
              m_axis_tlast  <= (cmd_len <= KW_LEN);
              m_axis_tuser  <= (cmd_len <= KW_LEN) && cmd_bad ? USER_BAD_FRAME_VALUE : 1'b0;
              m_axis_tid    <= cmd_id;
              m_axis_tdest  <= cmd_dest;
            end
          end
        end
        SEND: begin
          if (m_axis_tready) begin
            if (m_axis_tlast) begin
              state              <= IDLE;
              cmd_ready          <= 1'b1;
              status_busy        <= 1'b0;
              status_frame_count <= status_frame_count + 32'd1;
              m_axis_tvalid      <= 1'b0;
              m_axis_tlast       <= 1'b0;
              m_axis_tuser       <= 1'b0;
              m_axis_tdata       <= '0;
              m_axis_tkeep       <= '0;
            end else begin
              rem          <= rem_nxt;
              base         <= base_nxt;
              m_axis_tdata <= next_data;
              m_axis_tkeep <= next_keep;
              m_axis_tlast <= (rem_nxt <= KW_LEN);
              m_axis_tuser <= (rem_nxt <= KW_LEN) && bad_q ? USER_BAD_FRAME_VALUE : 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_frame_gen.sv
// tb/tb_axis_frame_gen.sv - directed and random frame checks against a byte-index reference model
module tb_axis_frame_gen;

  localparam int DW = 64;
  localparam int KW = DW / 8;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [LW-1:0] cmd_len = '0;
  logic [7:0]    cmd_seed = '0;
  logic [7:0]    cmd_id = '0;
  logic [7:0]    cmd_dest = '0;
  logic          cmd_bad = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b1;
  logic          m_axis_tlast;
  logic [7:0]    m_axis_tid;
  logic [7:0]    m_axis_tdest;
  logic          m_axis_tuser;
  logic          status_busy;
  logic          status_len_err;
  logic [31:0]   status_frame_count;

  int          total = 0;
  int          bad = 0;
  logic [31:0] fc_model = '0;
  logic [31:0] hdr_model = '0;

  always #5 clk = ~clk;

  axis_frame_gen #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_len(cmd_len), .cmd_seed(cmd_seed), .cmd_id(cmd_id), .cmd_dest(cmd_dest),
    .cmd_bad(cmd_bad), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast), .m_axis_tid(m_axis_tid),
    .m_axis_tdest(m_axis_tdest), .m_axis_tuser(m_axis_tuser),
    .status_busy(status_busy), .status_len_err(status_len_err),
    .status_frame_count(status_frame_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Byte idx of a frame: pattern seed+idx, zero beyond the frame, optional count header in bytes 0..3.
  function automatic logic [7:0] model_byte(input int len, input logic [7:0] seed, input int idx);
    if (idx >= len) return 8'h00;
`ifdef AXIS_FRAME_GEN_SEQ_HDR_EN
    if (idx < 4) return hdr_model[8*idx +: 8];
`endif
    return 8'((int'(seed) + idx) % 256);
  endfunction

  task automatic send_cmd(input int len, input logic [7:0] seed, input logic [7:0] id,
                          input logic [7:0] dest, input logic badf);
    chk("cmd_ready_idle", 64'(cmd_ready), 64'd1);
    cmd_len   = LW'(len);
    cmd_seed  = seed;
    cmd_id    = id;
    cmd_dest  = dest;
    cmd_bad   = badf;
    cmd_valid = 1'b1;
    hdr_model = fc_model;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // mode 0: tready always high, 1: toggled every cycle, 2: random
  task automatic recv_frame(input int len, input logic [7:0] seed, input logic [7:0] id,
                            input logic [7:0] dest, input logic badf, input int mode);
    int            beats;
    int            stalls;
    logic          done;
    logic          tr;
    logic [DW-1:0] ed;
    logic [KW-1:0] ek;
    logic          el;
    beats = (len + KW - 1) / KW;
    tr = m_axis_tready;
    for (int k = 0; k < beats; k++) begin
      ed = '0;
      ek = '0;
      for (int j = 0; j < KW; j++) begin
        ed[8*j +: 8] = model_byte(len, seed, k * KW + j);
        ek[j] = (k * KW + j) < len;
      end
      el = (k == beats - 1);
      stalls = 0;
      done = 1'b0;
      while (!done) begin
        chk("tvalid", 64'(m_axis_tvalid), 64'd1);
        chk("tdata", 64'(m_axis_tdata), 64'(ed));
        chk("tkeep", 64'(m_axis_tkeep), 64'(ek));
        chk("tlast", 64'(m_axis_tlast), 64'(el));
        chk("tuser", 64'(m_axis_tuser), 64'(el && badf));
        chk("tid", 64'(m_axis_tid), 64'(id));
        chk("tdest", 64'(m_axis_tdest), 64'(dest));
        chk("busy", 64'(status_busy), 64'd1);
        chk("cmd_ready_busy", 64'(cmd_ready), 64'd0);
        case (mode)
          1:       tr = ~tr;
          2:       tr = 1'($urandom_range(0, 1));
          default: tr = 1'b1;
        endcase
        if (stalls >= 20) tr = 1'b1;
        m_axis_tready = tr;
        @(posedge clk);
        @(negedge clk);
        if (tr) done = 1'b1;
        else stalls++;
      end
    end
    m_axis_tready = 1'b1;
    fc_model = fc_model + 32'd1;
    chk("idle_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("idle_busy", 64'(status_busy), 64'd0);
    chk("frame_count", 64'(status_frame_count), 64'(fc_model));
    chk("frame_count_step", 64'(status_frame_count), 64'(hdr_model + 32'd1));
  endtask

  task automatic frame(input int len, input logic [7:0] seed, input logic [7:0] id,
                       input logic [7:0] dest, input logic badf, input int mode);
    send_cmd(len, seed, id, dest, badf);
    recv_frame(len, seed, id, dest, badf, mode);
  endtask

  initial begin
    int          len;
    logic [7:0]  seed, id, dest;
    logic        badf;

    @(negedge clk);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("rst_tdata", 64'(m_axis_tdata), 64'd0);
    chk("rst_tkeep", 64'(m_axis_tkeep), 64'd0);
    chk("rst_tlast", 64'(m_axis_tlast), 64'd0);
    chk("rst_tuser", 64'(m_axis_tuser), 64'd0);
    chk("rst_busy", 64'(status_busy), 64'd0);
    chk("rst_len_err", 64'(status_len_err), 64'd0);
    chk("rst_count", 64'(status_frame_count), 64'd0);
    rst_n = 1'b1;
    #1 chk("rel_cmd_ready_before_edge", 64'(cmd_ready), 64'd0);
    @(negedge clk);
    chk("rel_cmd_ready", 64'(cmd_ready), 64'd1);

    frame(20, 8'h10, 8'd3, 8'd5, 1'b0, 0);
    frame(16, 8'hFE, 8'd1, 8'd2, 1'b0, 0);
    frame(9, 8'h40, 8'd7, 8'd9, 1'b1, 0);
    frame(40, 8'h80, 8'd4, 8'd6, 1'b0, 1);

    // zero-length command
    cmd_len = '0; cmd_seed = 8'h55; cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("len0_err", 64'(status_len_err), 64'd1);
    chk("len0_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("len0_cmd_ready", 64'(cmd_ready), 64'd1);
    @(negedge clk);
    chk("len0_err_pulse", 64'(status_len_err), 64'd0);
    chk("len0_tvalid2", 64'(m_axis_tvalid), 64'd0);
    chk("len0_count", 64'(status_frame_count), 64'(fc_model));

    for (int i = 0; i < 12; i++) begin
      len  = $urandom_range(1, 70);
      seed = 8'($urandom);
      id   = 8'($urandom);
      dest = 8'($urandom);
      badf = 1'($urandom_range(0, 1));
      frame(len, seed, id, dest, badf, 2);
    end

    frame(65535, 8'hA5, 8'd2, 8'd8, 1'b1, 0);

    // reset while beat 2 of a 64-byte frame is on the bus
    send_cmd(64, 8'h00, 8'd1, 8'd1, 1'b0);
    m_axis_tready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_beat2_valid", 64'(m_axis_tvalid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("mid_rst_count", 64'(status_frame_count), 64'd0);
    chk("mid_rst_tlast", 64'(m_axis_tlast), 64'd0);
    chk("mid_rst_cmd_ready", 64'(cmd_ready), 64'd0);
    fc_model = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    frame(8, 8'h30, 8'd6, 8'd7, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
